// File: rtl/lcd_write_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_write_sequencer
//
// Owns every write to the HD44780-style character LCD. After reset it waits
// for the panel's power-on delay and sends the four init commands. It then
// drains a small FIFO of command/data bytes pushed by the processor. Each byte
// gets one setup cycle, an enable pulse and a post-pulse busy wait. Clear and
// home commands (0x01/0x02 with rs=0) get the long wait.
//
// Ports:
//   clock      system clock, rising edge
//   resetn     asynchronous active-low reset
//   wr_en      push request (sampled on the clock edge)
//   wr_data    byte to queue
//   wr_rs      0 = command byte, 1 = character byte
//   wr_full    FIFO full (combinational)
//   busy       sequencer not idle or FIFO non-empty (combinational)
//   init_done  power-on init sequence finished
//   overflow   sticky: a push arrived while the FIFO was full
//   lcd_data   LCD data bus
//   lcd_rs     LCD register select
//   lcd_rw     LCD read/write, always write
//   lcd_en     LCD enable strobe
//   lcd_on     LCD power
//   lcd_blon   LCD backlight
// -----------------------------------------------------------------------------
module lcd_write_sequencer #(
   parameter int INIT_WAIT  = 750000,
   parameter int EN_PULSE   = 12,
   parameter int CMD_WAIT   = 2000,
   parameter int CLEAR_WAIT = 82000,
   parameter int FIFO_AW    = 3
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       wr_rs,
   output logic       wr_full,
   output logic       busy,
   output logic       init_done,
   output logic       overflow,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       lcd_on,
   output logic       lcd_blon
);

   localparam int                 DEPTH      = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DEPTH_C    = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   COUNT_ZERO = (FIFO_AW + 1)'(0);
   localparam logic [FIFO_AW:0]   COUNT_ONE  = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
   // Counters compare against N-1 so that a value N lasts exactly N cycles.
   localparam logic [23:0]        INIT_LAST  = 24'(INIT_WAIT - 1);
   localparam logic [23:0]        EN_LAST    = 24'(EN_PULSE - 1);
   localparam logic [23:0]        CMD_LAST   = 24'(CMD_WAIT - 1);
   localparam logic [23:0]        CLEAR_LAST = 24'(CLEAR_WAIT - 1);

   typedef enum logic [2:0] {
      ST_INIT_DELAY = 3'd0,
      ST_IDLE       = 3'd1,
      ST_SETUP      = 3'd2,
      ST_PULSE      = 3'd3,
      ST_WAIT       = 3'd4
   } state_t;

   // Power-on command ROM: function set, display on, clear, entry mode.
   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = 8'h38;
         2'd1:    b = 8'h0C;
         2'd2:    b = 8'h01;
         2'd3:    b = 8'h06;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // FIFO storage, {rs, data} per entry
   logic [8:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r;
   logic [FIFO_AW-1:0] rd_ptr_r;
   logic [FIFO_AW:0]   count_r;
   logic               push_s;
   logic               pop_s;
   logic [8:0]         head_s;

   // Sequencer state and its next-state values
   state_t      state_r,     state_n_s;
   logic [23:0] cnt_r,       cnt_n_s;
   logic [1:0]  idx_r,       idx_n_s;
   logic [7:0]  lcd_data_r,  data_n_s;
   logic        lcd_rs_r,    rs_n_s;
   logic        lcd_en_r,    en_n_s;
   logic        init_done_r, done_n_s;
   logic        overflow_r;
   logic        lcd_on_r;
   logic [23:0] wait_last_s;

   // Fullness uses the count before this edge, so a same-edge pop never
   // makes room for a push.
   assign wr_full = (count_r == DEPTH_C);
   assign push_s  = wr_en & ~wr_full;
   assign head_s  = mem_r[rd_ptr_r];
   assign busy    = (state_r != ST_IDLE) || (count_r != COUNT_ZERO);

   // The wait length follows the byte that is currently on the bus.
   assign wait_last_s = (!lcd_rs_r && ((lcd_data_r == 8'h01) || (lcd_data_r == 8'h02)))
                        ? CLEAR_LAST : CMD_LAST;

   assign init_done = init_done_r;
   assign overflow  = overflow_r;
   assign lcd_data  = lcd_data_r;
   assign lcd_rs    = lcd_rs_r;
   assign lcd_rw    = 1'b0;
   assign lcd_en    = lcd_en_r;
   assign lcd_on    = lcd_on_r;
   assign lcd_blon  = lcd_on_r;

   // FIFO storage write; contents need no reset because the pointers gate them
   always_ff @(posedge clock) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {wr_rs, wr_data};
      end
   end

   // Sequencer next-state, bus load and enable strobe decode
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = cnt_r;
      idx_n_s   = idx_r;
      data_n_s  = lcd_data_r;
      rs_n_s    = lcd_rs_r;
      en_n_s    = 1'b0;
      done_n_s  = init_done_r;
      pop_s     = 1'b0;
      case (state_r)
         ST_INIT_DELAY: begin
            if (cnt_r == INIT_LAST) begin
               cnt_n_s   = 24'd0;
               data_n_s  = init_byte(idx_r);
               rs_n_s    = 1'b0;
               state_n_s = ST_SETUP;
            end else begin
               cnt_n_s = cnt_r + 24'd1;
            end
         end
         ST_IDLE: begin
            if (count_r != COUNT_ZERO) begin
               pop_s     = 1'b1;
               rs_n_s    = head_s[8];
               data_n_s  = head_s[7:0];
               state_n_s = ST_SETUP;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            en_n_s    = 1'b1;
            cnt_n_s   = 24'd0;
            state_n_s = ST_PULSE;
         end
         ST_PULSE: begin
            if (cnt_r == EN_LAST) begin
               cnt_n_s   = 24'd0;
               state_n_s = ST_WAIT;
            end else begin
               en_n_s  = 1'b1;
               cnt_n_s = cnt_r + 24'd1;
            end
         end
         ST_WAIT: begin
            if (cnt_r == wait_last_s) begin
               cnt_n_s = 24'd0;
               if (init_done_r) begin
                  state_n_s = ST_IDLE;
               end else if (idx_r == 2'd3) begin
                  done_n_s  = 1'b1;
                  state_n_s = ST_IDLE;
               end else begin
                  // Next init command goes straight to setup, no idle cycle.
                  idx_n_s   = idx_r + 2'd1;
                  data_n_s  = init_byte(idx_r + 2'd1);
                  rs_n_s    = 1'b0;
                  state_n_s = ST_SETUP;
               end
            end else begin
               cnt_n_s = cnt_r + 24'd1;
            end
         end
         default: begin
            cnt_n_s   = 24'd0;
            state_n_s = ST_INIT_DELAY;
         end
      endcase
   end

   // State, FIFO bookkeeping and registered outputs
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_INIT_DELAY;
         cnt_r       <= 24'd0;
         idx_r       <= 2'd0;
         lcd_data_r  <= 8'h00;
         lcd_rs_r    <= 1'b0;
         lcd_en_r    <= 1'b0;
         init_done_r <= 1'b0;
         overflow_r  <= 1'b0;
         lcd_on_r    <= 1'b0;
         wr_ptr_r    <= {FIFO_AW{1'b0}};
         rd_ptr_r    <= {FIFO_AW{1'b0}};
         count_r     <= COUNT_ZERO;
      end else begin
         state_r     <= state_n_s;
         cnt_r       <= cnt_n_s;
         idx_r       <= idx_n_s;
         lcd_data_r  <= data_n_s;
         lcd_rs_r    <= rs_n_s;
         lcd_en_r    <= en_n_s;
         init_done_r <= done_n_s;
         overflow_r  <= overflow_r | (wr_en & wr_full);
         lcd_on_r    <= 1'b1;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + COUNT_ONE;
            2'b01:   count_r <= count_r - COUNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule
